// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, optional hardwired-zero entry, sequential clear sweep.
// Latency: read data 1 cycle after address; writes visible to the next read (same cycle with bypass).
// Backpressure: none; every port accepts each cycle in RUN, busy flags the DEPTH-cycle clear sweep.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile_mp #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic                            clock,
   input  logic                            clear,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]  rdAddr,
   output logic [NUM_READ*WIDTH-1:0]       rdData,
   input  logic [NUM_WRITE-1:0]            wrEnable,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wrAddr,
   input  logic [NUM_WRITE*WIDTH-1:0]      wrData,
   output logic                            busy,
   output logic                            wrCollision
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   typedef enum logic {RUN, SWEEP} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   sweep_idx, sweep_idx_nxt;
   logic [WIDTH-1:0]        mem [DEPTH];
   logic [NUM_READ*WIDTH-1:0] rd_nxt;
   logic                    coll_nxt;

   assign busy = (state == SWEEP);

   // State register; clear restarts the sweep from entry 0 and holds it there
   always_ff @(posedge clock) begin
      if (clear) begin
         state     <= SWEEP;
         sweep_idx <= '0;
      end else begin
         state     <= state_nxt;
         sweep_idx <= sweep_idx_nxt;
      end
   end

   // Next state: walk every entry once, return to RUN after the last one
   always_comb begin
      state_nxt     = state;
      sweep_idx_nxt = sweep_idx;
      if (state == SWEEP) begin
         sweep_idx_nxt = sweep_idx + 1'b1;
         if (sweep_idx == LAST_IDX) begin
            state_nxt = RUN;
         end
      end
   end

   // Storage has no reset so it can map to RAM; the sweep zeroes it instead.
   // Later write ports are applied last, so the higher index wins on a collision.
   always_ff @(posedge clock) begin
      if (!clear) begin
         if (state == SWEEP) begin
            mem[sweep_idx] <= '0;
         end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
               if (wrEnable[j] &&
                   !(ZERO_REG != 0 && wrAddr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                  mem[wrAddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wrData[j*WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   // Read data for the next cycle: storage, optional forwarding, then zero-entry mask
   always_comb begin
      rd_nxt = '0;
      if (state == RUN) begin
         for (int k = 0; k < NUM_READ; k++) begin
            rd_nxt[k*WIDTH +: WIDTH] = mem[rdAddr[k*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_WRITE_BYPASS_EN
            for (int j = 0; j < NUM_WRITE; j++) begin
               if (wrEnable[j] &&
                   wrAddr[j*ADDR_WIDTH +: ADDR_WIDTH] == rdAddr[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                  rd_nxt[k*WIDTH +: WIDTH] = wrData[j*WIDTH +: WIDTH];
               end
            end
`endif
            if (ZERO_REG != 0 && rdAddr[k*ADDR_WIDTH +: ADDR_WIDTH] == '0) begin
               rd_nxt[k*WIDTH +: WIDTH] = '0;
            end
         end
      end
   end

   // Collision: any two enabled ports on one address, except the hardwired-zero entry
   always_comb begin
      coll_nxt = 1'b0;
      if (state == RUN) begin
         for (int i = 0; i < NUM_WRITE; i++) begin
            for (int j = i + 1; j < NUM_WRITE; j++) begin
               if (wrEnable[i] && wrEnable[j] &&
                   wrAddr[i*ADDR_WIDTH +: ADDR_WIDTH] == wrAddr[j*ADDR_WIDTH +: ADDR_WIDTH] &&
                   !(ZERO_REG != 0 && wrAddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                  coll_nxt = 1'b1;
               end
            end
         end
      end
   end

   // Output registers; cleared synchronously
   always_ff @(posedge clock) begin
      if (clear) begin
         rdData      <= '0;
         wrCollision <= 1'b0;
      end else begin
         rdData      <= rd_nxt;
         wrCollision <= coll_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed stimulus against a behavioural register-file model.
// Latency: expectations are queued at each posedge and compared at the following negedge.
// Backpressure: none; the monitor consumes one expectation per cycle.
module tb_regfile_mp;

   localparam int W     = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int ZR    = 1;

   logic          clock;
   logic          clear;
   logic [2*AW-1:0] rdAddr;
   logic [2*W-1:0]  rdData;
   logic [1:0]      wrEnable;
   logic [2*AW-1:0] wrAddr;
   logic [2*W-1:0]  wrData;
   logic            busy;
   logic            wrCollision;

   regfile_mp #(
      .WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(2), .NUM_WRITE(2), .ZERO_REG(ZR)
   ) dut (
      .clock(clock), .clear(clear), .rdAddr(rdAddr), .rdData(rdData),
      .wrEnable(wrEnable), .wrAddr(wrAddr), .wrData(wrData),
      .busy(busy), .wrCollision(wrCollision)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] rd0;
      logic [W-1:0] rd1;
      logic         coll;
      logic         bsy;
   } exp_t;

   exp_t exp_q[$];
   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [W-1:0] mm [DEPTH];
   int           remaining = 0;
   bit           started   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [W-1:0] model_read(input logic [AW-1:0] a, input logic [1:0] en,
                                               input logic [AW-1:0] wa0, input logic [W-1:0] wd0,
                                               input logic [AW-1:0] wa1, input logic [W-1:0] wd1);
      logic [W-1:0] v;
      v = mm[a];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (en[0] && wa0 == a) v = wd0;
      if (en[1] && wa1 == a) v = wd1;
`else
      if (en[0] && wa0 == a && wd0 === 'x) v = 'x;
      if (en[1] && wa1 == a && wd1 === 'x) v = 'x;
`endif
      if (ZR != 0 && a == 0) v = '0;
      return v;
   endfunction

   // Drive one cycle, predict the response, queue it after the edge
   task automatic cyc(input logic clr, input logic [1:0] en,
                      input logic [AW-1:0] wa0, input logic [W-1:0] wd0,
                      input logic [AW-1:0] wa1, input logic [W-1:0] wd1,
                      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      exp_t e;
      clear    = clr;
      wrEnable = en;
      wrAddr   = {wa1, wa0};
      wrData   = {wd1, wd0};
      rdAddr   = {ra1, ra0};
      e.rd0 = '0; e.rd1 = '0; e.coll = 1'b0; e.bsy = 1'b0;
      if (clr) begin
         started   = 1;
         remaining = DEPTH;
         for (int i = 0; i < DEPTH; i++) mm[i] = '0;
         e.bsy = 1'b1;
      end else if (remaining > 0) begin
         remaining--;
         e.bsy = (remaining > 0);
      end else begin
         e.rd0  = model_read(ra0, en, wa0, wd0, wa1, wd1);
         e.rd1  = model_read(ra1, en, wa0, wd0, wa1, wd1);
         e.coll = (en == 2'b11) && (wa0 == wa1) && !(ZR != 0 && wa0 == 0);
         if (en[0] && !(ZR != 0 && wa0 == 0)) mm[wa0] = wd0;
         if (en[1] && !(ZR != 0 && wa1 == 0)) mm[wa1] = wd1;
      end
      @(posedge clock);
      if (started) exp_q.push_back(e);
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
      cyc(1'b0, 2'b00, '0, '0, '0, '0, ra0, ra1);
   endtask

   task automatic rand_cyc(input bit allow_clear);
      logic [1:0] en;
      logic [AW-1:0] wa0, wa1, ra0, ra1;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      en  = 2'($urandom_range(0, 3));
      wa0 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wa1 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ra0 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ra1 = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom);
      cyc(allow_clear && ($urandom_range(0, 199) == 0), en, wa0, $urandom, wa1, $urandom, ra0, ra1);
   endtask

   // Monitor: the DUT presents a result every cycle; compare against the oldest expectation
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("rdData0", rdData[W-1:0], e.rd0);
         chk("rdData1", rdData[2*W-1:W], e.rd1);
         chk("wrCollision", {31'b0, wrCollision}, {31'b0, e.coll});
         chk("busy", {31'b0, busy}, {31'b0, e.bsy});
      end
   end

   initial begin
      clear = 1'b0; wrEnable = '0; wrAddr = '0; wrData = '0; rdAddr = '0;
      @(posedge clock); #1;

      // Clear, then sweep with random write attempts that must be ignored
      cyc(1'b1, 2'b00, '0, '0, '0, '0, '0, '0);
      for (int i = 0; i < DEPTH; i++) rand_cyc(1'b0);
      for (int i = 0; i < DEPTH / 2; i++) idle(AW'(2 * i), AW'(2 * i + 1));

      // Basic write and read on both ports
      cyc(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, '0, '0, '0, '0);
      idle(5'd5, 5'd5);
      idle('0, '0);

      // Zero entry: both ports write address 0, no collision, reads stay 0
      cyc(1'b0, 2'b11, 5'd0, 32'h12345678, 5'd0, 32'h12345678, '0, '0);
      idle(5'd0, 5'd0);

      // Collision on address 9
      cyc(1'b0, 2'b11, 5'd9, 32'h11111111, 5'd9, 32'h22222222, '0, '0);
      idle(5'd9, 5'd9);
      idle(5'd9, 5'd5);

      // Same-cycle read of a written address
      cyc(1'b0, 2'b01, 5'd3, 32'h00000001, '0, '0, '0, '0);
      cyc(1'b0, 2'b01, 5'd3, 32'hA5A5A5A5, '0, '0, 5'd3, 5'd3);
      idle(5'd3, 5'd3);

      // Random traffic with occasional clears
      for (int i = 0; i < 400; i++) rand_cyc(1'b1);
      for (int i = 0; i < DEPTH + 2; i++) idle(AW'($urandom), AW'($urandom));

      // Reset mid-sweep, then a blocked write to address 31 during the sweep
      cyc(1'b1, 2'b00, '0, '0, '0, '0, '0, '0);
      for (int i = 0; i < 10; i++) idle(5'd31, 5'd31);
      cyc(1'b1, 2'b00, '0, '0, '0, '0, '0, '0);
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b0, 2'b10, '0, '0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31);
      idle(5'd31, 5'd31);
      idle(5'd31, 5'd0);

      @(negedge clock);
      @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
